// File: rtl/mul_pkg.sv
// Shared width and operand/result type for the pipelined multiplier.
package mul_pkg;

    // Operand and result width used by default throughout the block.
    localparam int unsigned WIDTH_DEFAULT = 32;

    // Operand/result word at the default width.
    typedef logic [WIDTH_DEFAULT-1:0] word_t;

    // Depth of a binary adder tree that sums n partial products.
    function automatic int unsigned tree_levels(input int unsigned n);
        return (n <= 1) ? 0 : $clog2(n);
    endfunction

endpackage : mul_pkg

// File: rtl/mul_array.sv
// Combinational WIDTH x WIDTH truncated multiplier.
// Builds one shifted partial product per multiplier bit and sums them with a
// balanced adder tree. Every term and every sum is kept at WIDTH bits because
// only the low word of the product is ever needed.
module mul_array
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] p_c
);

    localparam int unsigned LEVELS = tree_levels(WIDTH);
    localparam int unsigned NPAD   = 32'd1 << LEVELS;
    localparam int unsigned NNODES = 2 * NPAD - 1;

    // Heap-ordered tree: node 0 is the root, leaves start at NPAD-1.
    logic [WIDTH-1:0] node [NNODES];

    genvar k;

    // Leaves: partial product for each multiplier bit, zero for padding slots.
    generate
        for (k = 0; k < NPAD; k++) begin : g_leaf
            if (k < WIDTH) begin : g_pp
                assign node[NPAD-1+k] = {WIDTH{b[k]}} & (a << k);
            end else begin : g_pad
                assign node[NPAD-1+k] = '0;
            end
        end
    endgenerate

    // Internal nodes: pairwise sums, carries beyond WIDTH are dropped.
    generate
        for (k = 0; k < NPAD - 1; k++) begin : g_sum
            assign node[k] = node[2*k+1] + node[2*k+2];
        end
    endgenerate

    assign p_c = node[0];

endmodule : mul_array

// File: rtl/mul.sv
// Two-stage pipelined unsigned multiplier returning the low WIDTH bits.
// Edge N captures A/B, edge N+1 registers their product into C. Synchronous
// reset clears both stages so no in-flight product survives a reset.
module mul
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C
);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] prod_c;

    mul_array #(
        .WIDTH (WIDTH)
    ) u_array (
        .a   (a_q),
        .b   (b_q),
        .p_c (prod_c)
    );

    // Operand capture and result register; reset wins over capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_q <= '0;
            b_q <= '0;
            C   <= '0;
        end else begin
            a_q <= A;
            b_q <= B;
            C   <= prod_c;
        end
    end

endmodule : mul

// File: tb/tb_mul.sv
// Directed, table-driven bench for the pipelined multiplier.
module tb_mul;
    import mul_pkg::*;

    typedef struct {
        word_t a;
        word_t b;
        word_t c;
    } vec_t;

    logic  CLK;
    logic  RST;
    word_t A;
    word_t B;
    word_t C;

    int tests;
    int fails;

    vec_t vecs[$];

    mul #(.WIDTH(WIDTH_DEFAULT)) dut (
        .CLK (CLK),
        .RST (RST),
        .A   (A),
        .B   (B),
        .C   (C)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input word_t act, input word_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: C=%h expected %h", name, act, exp);
        end
    endtask

    initial begin
        CLK   = 1'b0;
        RST   = 1'b1;
        A     = '0;
        B     = '0;
        tests = 0;
        fails = 0;

        // Reset state
        repeat (2) @(negedge CLK);
        check("reset", C, 32'h0);
        A = 32'h1234_5678;
        B = 32'h9ABC_DEF0;
        repeat (2) @(negedge CLK);
        check("reset_priority", C, 32'h0);
        RST = 1'b0;

        // Sweep 1..10 x 1..10 plus directed corner vectors
        for (int i = 1; i <= 10; i++)
            for (int j = 1; j <= 10; j++)
                vecs.push_back('{a: word_t'(i), b: word_t'(j), c: word_t'(i * j)});
        vecs.push_back('{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, c: 32'h0000_0001});
        vecs.push_back('{a: 32'h0001_0000, b: 32'h0001_0000, c: 32'h0000_0000});
        vecs.push_back('{a: 32'hFFFF_FFFE, b: 32'h0000_0003, c: 32'hFFFF_FFFA});
        vecs.push_back('{a: 32'h0000_0000, b: 32'h1234_5678, c: 32'h0000_0000});
        vecs.push_back('{a: 32'h1234_5678, b: 32'h0000_0000, c: 32'h0000_0000});
        vecs.push_back('{a: 32'h0000_0001, b: 32'hDEAD_BEEF, c: 32'hDEAD_BEEF});
        vecs.push_back('{a: 32'hDEAD_BEEF, b: 32'h0000_0001, c: 32'hDEAD_BEEF});
        vecs.push_back('{a: 32'h0000_FFFF, b: 32'h0000_FFFF, c: 32'hFFFE_0001});
        vecs.push_back('{a: 32'h8000_0000, b: 32'h0000_0002, c: 32'h0000_0000});
        vecs.push_back('{a: 32'hFFFF_FFFF, b: 32'h0000_0005, c: 32'hFFFF_FFFB});

        foreach (vecs[k]) begin
            A = vecs[k].a;
            B = vecs[k].b;
            @(negedge CLK);
            @(negedge CLK);
            check($sformatf("vec%0d_%h*%h", k, vecs[k].a, vecs[k].b), C, vecs[k].c);
        end

        // Held operands: C stays constant
        A = 32'd6;
        B = 32'd7;
        repeat (2) @(negedge CLK);
        check("hold0", C, 32'd42);
        @(negedge CLK);
        check("hold1", C, 32'd42);
        @(negedge CLK);
        check("hold2", C, 32'd42);

        // Streaming: one new pair per cycle
        A = 32'd3; B = 32'd4;
        @(negedge CLK);
        A = 32'd5; B = 32'd6;
        @(negedge CLK);
        check("stream_3x4", C, 32'd12);
        A = 32'd7; B = 32'd8;
        @(negedge CLK);
        check("stream_5x6", C, 32'd30);
        A = 32'd9; B = 32'd9;
        @(negedge CLK);
        check("stream_7x8", C, 32'd56);
        @(negedge CLK);
        check("stream_9x9", C, 32'd81);

        // Reset mid-stream flushes the in-flight 5*6
        A = 32'd5; B = 32'd6;
        @(negedge CLK);
        RST = 1'b1;
        A = 32'd11; B = 32'd13;
        @(negedge CLK);
        check("midrst_flush", C, 32'd0);
        RST = 1'b0;
        A = 32'd2; B = 32'd2;
        @(negedge CLK);
        check("midrst_gap", C, 32'd0);
        @(negedge CLK);
        check("midrst_first", C, 32'd4);
        A = 32'd100; B = 32'd3;
        @(negedge CLK);
        check("midrst_still4", C, 32'd4);
        @(negedge CLK);
        check("midrst_next", C, 32'd300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_mul

// File: doc/mul.md
MUL -- requirements
Module: mul

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width; all behaviour below is specified at WIDTH=32.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 CLK  input  1  clock; all state updates on the rising edge.
REQ-004 RST  input  1  synchronous, active-high reset, sampled on the rising edge of CLK.
REQ-005 A  input  WIDTH  multiplicand, unsigned.
REQ-006 B  input  WIDTH  multiplier, unsigned.
REQ-007 C  output  WIDTH  product, registered.

Function
REQ-008 C SHALL equal the low WIDTH bits of the unsigned product A*B, i.e. (A*B) mod 2^WIDTH.
REQ-009 The upper WIDTH bits of the full product SHALL be discarded, with no overflow flag.
REQ-010 Because only the low word is returned, the result SHALL be identical for signed (two's-complement) operands.
REQ-011 Stage 1: on rising edge N, the block SHALL capture A and B into input registers.
REQ-012 Stage 2: on rising edge N+1, the block SHALL register the product of the captured operands into C.
REQ-013 Latency SHALL be exactly 2 rising edges from operand capture to C update.
REQ-014 C SHALL be stable and readable from the falling edge after edge N+1 until edge N+2.
REQ-015 The pipeline SHALL be fully pipelined, accepting new operands every cycle (throughput 1 per clock).
REQ-016 There is no handshake or valid signal; every captured operand pair produces a result 2 edges later.
REQ-017 The product path between the input registers and C SHALL be purely combinational and complete within one clock period.
REQ-018 Held operands SHALL produce a constant C from the second edge onward.
REQ-019 Operand changes between edges SHALL NOT affect C until captured.
REQ-020 Zero rule: if either operand is 0, C SHALL be 0.
REQ-021 Identity rule: if either operand is 1, C SHALL equal the other operand.

Reset
REQ-022 While RST is high at a rising edge, the input registers and C SHALL be cleared to 0.
REQ-023 Reset SHALL take priority over operand capture.
REQ-024 Reset asserted mid-stream SHALL flush all in-flight products; no pre-reset result may appear on C afterwards.
REQ-025 After RST deasserts, operands captured at the first edge with RST low SHALL appear on C one edge later, preserving the 2-edge latency.
REQ-026 C SHALL remain 0 between reset release and that first result.

Structure
REQ-027 Package mul_pkg SHALL hold the WIDTH default constant and the operand/result typedef (word_t).
REQ-028 One sub-module, mul_array, SHALL implement the combinational WIDTH x WIDTH to WIDTH truncated product.
REQ-029 mul_array SHALL be built as a shift-add partial-product array with an adder tree.
REQ-030 The pipeline registers and reset logic SHALL reside in mul, not in mul_array.
REQ-031 The design SHALL contain no latches, use no initial blocks for state, and be synthesizable.

Verification
REQ-032 Sweep: A=1..10 x B=1..10, each pair applied at a negedge, C checked at the negedge after 2 posedges (e.g. 7*9 -> 63, 10*10 -> 100).
REQ-033 Wrap: A=0xFFFFFFFF, B=0xFFFFFFFF -> C=0x00000001; A=0x00010000, B=0x00010000 -> C=0x00000000.
REQ-034 Mixed sign: A=0xFFFFFFFE (-2), B=3 -> C=0xFFFFFFFA.
REQ-035 Streaming: apply 3*4, 5*6, 7*8 on consecutive edges -> C shows 12, 30, 56 on consecutive edges, starting 2 edges after the first capture.
REQ-036 Reset mid-stream: RST high for one edge while 5*6 is in flight -> C=0 after that edge; 5*6=30 never appears; next operands 2*2 -> C=4 with 2-edge latency.
REQ-037 Zero/identity: 0*0x12345678 -> 0; 1*0xDEADBEEF -> 0xDEADBEEF.
